// File: rtl/mem_arbiter2.sv
// mem_arbiter2: round-robin two-port arbiter for the image memory,
// with burst lock and per-port read-valid return.
module mem_arbiter2 #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4,
  parameter int READ_LAT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_dataW,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_dataW,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dataW,
  output logic              en,
  output logic              we,
  input  logic [DATA_W-1:0] dataR
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    O_NONE,
    O_P0,
    O_P1
  } own_e;

  own_e owner, owner_n;
  logic last, last_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [READ_LAT-1:0] tv, tp;
  logic g0, g1, room;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner <= O_NONE;
      last  <= 1'b1;
      cnt   <= '0;
      tv    <= '0;
      tp    <= '0;
    end else begin
      owner <= owner_n;
      last  <= last_n;
      cnt   <= cnt_n;
      tv[0] <= en & ~we;
      tp[0] <= g1;
      for (int i = 1; i < READ_LAT; i++) begin
        tv[i] <= tv[i-1];
        tp[i] <= tp[i-1];
      end
    end
  end

  // owner keeps the grant until it saturates while the other waits
  always_comb begin
    g0   = 1'b0;
    g1   = 1'b0;
    room = (cnt < CMAX);
    unique case (owner)
      O_P0: begin
        if (m0_req && (room || !m1_req)) g0 = 1'b1;
        else if (m1_req)                 g1 = 1'b1;
      end
      O_P1: begin
        if (m1_req && (room || !m0_req)) g1 = 1'b1;
        else if (m0_req)                 g0 = 1'b1;
      end
      default: begin
        if (m0_req && m1_req) begin
          g0 = last;
          g1 = ~last;
        end else begin
          g0 = m0_req;
          g1 = m1_req;
        end
      end
    endcase
    if (reset) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end
  end

  always_comb begin
    owner_n = O_NONE;
    last_n  = last;
    cnt_n   = '0;
    if (g0) begin
      owner_n = O_P0;
      last_n  = 1'b0;
      if (owner != O_P0) cnt_n = CW'(1);
      else               cnt_n = room ? cnt + CW'(1) : cnt;
    end else if (g1) begin
      owner_n = O_P1;
      last_n  = 1'b1;
      if (owner != O_P1) cnt_n = CW'(1);
      else               cnt_n = room ? cnt + CW'(1) : cnt;
    end
  end

  always_comb begin
    addr  = '0;
    dataW = '0;
    we    = 1'b0;
    unique case (1'b1)
      g0: begin
        addr  = m0_addr;
        dataW = m0_dataW;
        we    = m0_we;
      end
      g1: begin
        addr  = m1_addr;
        dataW = m1_dataW;
        we    = m1_we;
      end
      default: ;
    endcase
  end

  assign m0_gnt    = g0;
  assign m1_gnt    = g1;
  assign en        = g0 | g1;
  assign rdata     = dataR;
  assign m0_rvalid = tv[READ_LAT-1] & ~tp[READ_LAT-1] & ~reset;
  assign m1_rvalid = tv[READ_LAT-1] &  tp[READ_LAT-1] & ~reset;

endmodule

// File: tb/tb_mem_arbiter2.sv
// tb_mem_arbiter2: randomized bench against a beat-level reference model,
// READ_LAT=1 (dut a) and READ_LAT=2 (dut b) sharing one stimulus.
module tb_mem_arbiter2;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_dataW, m1_dataW;

  logic a_g0, a_g1, a_rv0, a_rv1, a_en, a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_rdata, a_dw, a_dr;
  logic b_g0, b_g1, b_rv0, b_rv1, b_en, b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_rdata, b_dw, b_dr, b_st;

  mem_arbiter2 #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .READ_LAT(1)) dut_a (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_dataW(m0_dataW),
    .m0_gnt(a_g0), .m0_rvalid(a_rv0),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_dataW(m1_dataW),
    .m1_gnt(a_g1), .m1_rvalid(a_rv1),
    .rdata(a_rdata), .addr(a_addr), .dataW(a_dw), .en(a_en), .we(a_we),
    .dataR(a_dr)
  );

  mem_arbiter2 #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .READ_LAT(2)) dut_b (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_dataW(m0_dataW),
    .m0_gnt(b_g0), .m0_rvalid(b_rv0),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_dataW(m1_dataW),
    .m1_gnt(b_g1), .m1_rvalid(b_rv1),
    .rdata(b_rdata), .addr(b_addr), .dataW(b_dw), .en(b_en), .we(b_we),
    .dataR(b_dr)
  );

  // memory models: preloaded with (i+1)*0x11 while reset is high
  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= DW'(i + 1) * 32'h11;
    end else if (a_en && a_we) begin
      mem_a[a_addr[7:0]] <= a_dw;
    end
    a_dr <= mem_a[a_addr[7:0]];
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= DW'(i + 1) * 32'h11;
    end else if (b_en && b_we) begin
      mem_b[b_addr[7:0]] <= b_dw;
    end
    b_st <= mem_b[b_addr[7:0]];
    b_dr <= b_st;
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } beat_t;

  typedef struct {
    int            due;
    int            port;
    logic [DW-1:0] data;
  } pend_t;

  beat_t q0[$];
  beat_t q1[$];
  pend_t pend1[$];
  pend_t pend2[$];
  logic [DW-1:0] ref_mem [256];

  int own = -1;
  int last = 1;
  int run = 0;
  int cyc = 0;
  int nerr = 0;
  int nchk = 0;

  int gseq[$];
  int gcyc[$];
  logic [DW-1:0] loga0[$];
  logic [DW-1:0] loga1[$];
  int logb_port[$];
  int logb_cyc[$];

  // reference arbitration: owner keeps going below the burst limit
  // or while the other side is idle; otherwise hand over round-robin
  function automatic int pick(input logic r0, input logic r1);
    int oth;
    logic ro, rx;
    if (own >= 0) begin
      oth = 1 - own;
      ro = (own == 0) ? r0 : r1;
      rx = (oth == 0) ? r0 : r1;
      if (ro && (run < MB || !rx)) return own;
      if (rx) return oth;
    end
    if (r0 && r1) return 1 - last;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    own = -1;
    last = 1;
    run = 0;
    pend1.delete();
    pend2.delete();
    for (int i = 0; i < 256; i++) ref_mem[i] = DW'(i + 1) * 32'h11;
  endtask

  task automatic clr_logs();
    gseq.delete();
    gcyc.delete();
    loga0.delete();
    loga1.delete();
    logb_port.delete();
    logb_cyc.delete();
  endtask

  task automatic step();
    int g, xa, xb;
    beat_t b;
    pend_t p;
    logic e_en, e_we;
    logic [AW-1:0] e_ad;
    logic [DW-1:0] e_dw;
    m0_req = (q0.size() > 0);
    m1_req = (q1.size() > 0);
    if (m0_req) begin
      m0_we = q0[0].we; m0_addr = q0[0].a; m0_dataW = q0[0].d;
    end else begin
      m0_we = 1'($urandom); m0_addr = AW'($urandom); m0_dataW = $urandom;
    end
    if (m1_req) begin
      m1_we = q1[0].we; m1_addr = q1[0].a; m1_dataW = q1[0].d;
    end else begin
      m1_we = 1'($urandom); m1_addr = AW'($urandom); m1_dataW = $urandom;
    end
    @(negedge clk);
    g = reset ? -1 : pick(m0_req, m1_req);
    b = '{we: 1'b0, a: '0, d: '0};
    if (g == 0) b = q0[0];
    if (g == 1) b = q1[0];
    e_en = (g >= 0);
    e_we = (g >= 0) && b.we;
    e_ad = (g >= 0) ? b.a : '0;
    e_dw = (g >= 0) ? b.d : '0;
    xa = (!reset && pend1.size() > 0 && pend1[0].due == cyc) ? pend1[0].port : -1;
    xb = (!reset && pend2.size() > 0 && pend2[0].due == cyc) ? pend2[0].port : -1;
    nchk++;
    if (a_g0 !== (g == 0) || a_g1 !== (g == 1)) begin
      nerr++;
      $display("FAIL gnt_a c%0d: got %b%b want port %0d", cyc, a_g1, a_g0, g);
    end
    nchk++;
    if (b_g0 !== (g == 0) || b_g1 !== (g == 1)) begin
      nerr++;
      $display("FAIL gnt_b c%0d: got %b%b want port %0d", cyc, b_g1, b_g0, g);
    end
    nchk++;
    if (a_en !== e_en || a_we !== e_we) begin
      nerr++;
      $display("FAIL en_we c%0d: got %b%b want %b%b", cyc, a_en, a_we, e_en, e_we);
    end
    nchk++;
    if (a_addr !== e_ad || a_dw !== e_dw) begin
      nerr++;
      $display("FAIL mux c%0d: got %h/%h want %h/%h", cyc, a_addr, a_dw, e_ad, e_dw);
    end
    nchk++;
    if (a_rv0 !== (xa == 0) || a_rv1 !== (xa == 1)) begin
      nerr++;
      $display("FAIL rvalid_a c%0d: got %b%b want port %0d", cyc, a_rv1, a_rv0, xa);
    end
    nchk++;
    if (b_rv0 !== (xb == 0) || b_rv1 !== (xb == 1)) begin
      nerr++;
      $display("FAIL rvalid_b c%0d: got %b%b want port %0d", cyc, b_rv1, b_rv0, xb);
    end
    if (xa >= 0) begin
      nchk++;
      if (a_rdata !== pend1[0].data) begin
        nerr++;
        $display("FAIL rdata_a c%0d: got %h want %h", cyc, a_rdata, pend1[0].data);
      end
    end
    if (xb >= 0) begin
      nchk++;
      if (b_rdata !== pend2[0].data) begin
        nerr++;
        $display("FAIL rdata_b c%0d: got %h want %h", cyc, b_rdata, pend2[0].data);
      end
    end
    if (a_g0) begin gseq.push_back(0); gcyc.push_back(cyc); end
    else if (a_g1) begin gseq.push_back(1); gcyc.push_back(cyc); end
    if (a_rv0) loga0.push_back(a_rdata);
    if (a_rv1) loga1.push_back(a_rdata);
    if (b_rv0 || b_rv1) begin
      logb_port.push_back(b_rv1 ? 1 : 0);
      logb_cyc.push_back(cyc);
    end
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (xa >= 0) void'(pend1.pop_front());
      if (xb >= 0) void'(pend2.pop_front());
      if (g >= 0) begin
        if (b.we) begin
          ref_mem[b.a[7:0]] = b.d;
        end else begin
          p = '{due: cyc + 1, port: g, data: ref_mem[b.a[7:0]]};
          pend1.push_back(p);
          p.due = cyc + 2;
          pend2.push_back(p);
        end
        run = (g == own) ? run + 1 : 1;
        own = g;
        last = g;
        if (g == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
      end else begin
        own = -1;
        run = 0;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic drain(input int max);
    int k = 0;
    while ((q0.size() > 0 || q1.size() > 0) && k < max) begin
      step();
      k++;
    end
    nchk++;
    if (q0.size() > 0 || q1.size() > 0) begin
      nerr++;
      $display("FAIL drain_timeout: got %0d/%0d beats left want 0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
    repeat (3) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  function automatic beat_t rd(input int a);
    return '{we: 1'b0, a: AW'(a), d: $urandom};
  endfunction

  function automatic beat_t wr(input int a, input logic [DW-1:0] d);
    return '{we: 1'b1, a: AW'(a), d: d};
  endfunction

  task automatic test_reset();
    q0.push_back(rd(5));
    q1.push_back(rd(6));
    reset = 1'b1;
    repeat (2) step();
    nchk++;
    if (gseq.size() !== 0) begin
      nerr++;
      $display("FAIL reset_gnt: got %0d grants want 0", gseq.size());
    end
    q0.delete();
    q1.delete();
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_m0();
    logic [DW-1:0] ex [3] = '{32'h11, 32'h22, 32'h33};
    clr_logs();
    for (int i = 0; i < 3; i++) q0.push_back(rd(i));
    drain(10);
    nchk++;
    if (loga0.size() !== 3 || loga1.size() !== 0) begin
      nerr++;
      $display("FAIL single_cnt: got %0d/%0d want 3/0", loga0.size(), loga1.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (i < loga0.size()) begin
        nchk++;
        if (loga0[i] !== ex[i]) begin
          nerr++;
          $display("FAIL single_data%0d: got %h want %h", i, loga0[i], ex[i]);
        end
      end
    end
  endtask

  task automatic test_tie_rr();
    do_reset();
    clr_logs();
    for (int i = 0; i < 12; i++) begin
      q0.push_back(wr(32 + i, $urandom));
      q1.push_back(wr(48 + i, $urandom));
    end
    drain(40);
    nchk++;
    if (gseq.size() !== 24) begin
      nerr++;
      $display("FAIL rr_len: got %0d want 24", gseq.size());
    end
    for (int i = 0; i < 24; i++) begin
      if (i < gseq.size()) begin
        nchk++;
        if (gseq[i] !== (i / MB) % 2) begin
          nerr++;
          $display("FAIL rr_seq%0d: got P%0d want P%0d", i, gseq[i], (i / MB) % 2);
        end
      end
    end
  endtask

  task automatic test_m1_alone();
    int n = 0;
    clr_logs();
    for (int i = 0; i < 10; i++) q1.push_back(rd(i));
    repeat (10) begin
      step();
      if (gseq.size() > n) n++;
    end
    nchk++;
    if (n !== 10 || gseq.sum() !== 10) begin
      nerr++;
      $display("FAIL m1_alone: got %0d grants (sum %0d) want 10", n, gseq.sum());
    end
    drain(5);
  endtask

  task automatic test_interleave();
    clr_logs();
    q0.push_back(rd(16));
    q1.push_back(wr(32, 32'hDEADBEEF));
    q1.push_back(rd(32));
    drain(10);
    nchk++;
    if (loga0.size() !== 1 || loga1.size() !== 1) begin
      nerr++;
      $display("FAIL inter_cnt: got %0d/%0d want 1/1", loga0.size(), loga1.size());
    end else begin
      nchk++;
      if (loga1[0] !== 32'hDEADBEEF) begin
        nerr++;
        $display("FAIL inter_data: got %h want deadbeef", loga1[0]);
      end
    end
  endtask

  task automatic test_alt_lat2();
    clr_logs();
    q0.push_back(rd(1));
    step();
    q1.push_back(rd(2));
    step();
    q0.push_back(rd(3));
    step();
    repeat (3) step();
    nchk++;
    if (logb_port.size() !== 3 || gcyc.size() !== 3) begin
      nerr++;
      $display("FAIL alt_cnt: got %0d/%0d want 3/3", logb_port.size(), gcyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        nchk++;
        if (logb_port[i] !== i % 2 || logb_cyc[i] !== gcyc[i] + 2) begin
          nerr++;
          $display("FAIL alt%0d: got P%0d@%0d want P%0d@%0d", i,
                   logb_port[i], logb_cyc[i], i % 2, gcyc[i] + 2);
        end
      end
    end
  endtask

  task automatic test_reset_inflight();
    q0.push_back(rd(7));
    step();
    q1.push_back(rd(8));
    step();
    clr_logs();
    do_reset();
    repeat (4) step();
    nchk++;
    if (loga0.size() + loga1.size() + logb_port.size() !== 0) begin
      nerr++;
      $display("FAIL stale_rvalid: got %0d pulses want 0",
               loga0.size() + loga1.size() + logb_port.size());
    end
    clr_logs();
    q0.push_back(rd(9));
    q1.push_back(rd(10));
    drain(6);
    nchk++;
    if (gseq.size() < 1 || gseq[0] !== 0) begin
      nerr++;
      $display("FAIL post_reset_tie: got %0d grants first P%0d want P0",
               gseq.size(), gseq.size() > 0 ? gseq[0] : -1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (q0.size() < 3 && $urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 1) == 1) q0.push_back(wr($urandom_range(0, 63), $urandom));
        else q0.push_back(rd($urandom_range(0, 63)));
      end
      if (q1.size() < 3 && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 1) q1.push_back(wr($urandom_range(0, 63), $urandom));
        else q1.push_back(rd($urandom_range(0, 63)));
      end
      reset = (i == 200);
      step();
      if (i == 200) begin
        q0.delete();
        q1.delete();
      end
    end
    reset = 1'b0;
    drain(40);
  endtask

  initial begin
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_dataW = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_dataW = '0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_single_m0();
    test_tie_rr();
    test_m1_alone();
    test_interleave();
    test_alt_lat2();
    test_reset_inflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
